piano_key_debounce: RTL and testbench
=====================================

# piano_key_debounce

Front-end stage of the piano datapath: it conditions the eight raw key switches `t0`..`t7` and hands a clean chord vector to the tone-generation stage. Each key gets a 2-flop synchronizer and a per-key debounce counter. Whenever the debounced key set differs from the last chord accepted downstream, the block presents the new set through a valid/ready handshake. The downstream `piano` stage consumes `chord` in its LISTEN state; a release to all-zero is reported like any other chord and means silence.

## Interface
- `DEBOUNCE_CYCLES`, default 50000 (1 ms at 50 MHz): consecutive cycles a synchronized key level must differ from its debounced value before it is accepted; legal range 2..2^CNT_W-1.
- `CNT_W`, default 16: width of each per-key debounce counter.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `t0`..`t7`  in  1 each  raw, asynchronous key switches, 1 = pressed.
- `chord`  out  8  debounced chord offered downstream; bit mapping `chord = {t0,t1,t2,t3,t4,t5,t6,t7}`, so `chord[7]`=t0 and `chord[0]`=t7.
- `chord_valid`  out  1  `chord` holds an unaccepted new chord.
- `chord_ready`  in  1  downstream accepts `chord` when high together with `chord_valid`.
- `any_key`  out  1  OR of the 8 debounced key levels (not the reported chord).

## Operation
- Synchronizer: per key, `s1 <= raw`, then `s2 <= s1`.
- Debounce, per key, with `db` = debounced level and `cnt` = counter:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `db`.
  - Keys are independent; several keys may flip on the same edge.
- `reported` register (8 bits) holds the last chord accepted downstream.
- Output FSM, two states:
  - IDLE: `chord_valid=0`. If `dbvec != reported`, load `chord <= dbvec`, `chord_valid <= 1`, go to OFFER.
  - OFFER: `chord` and `chord_valid` are held constant while `chord_ready=0`, regardless of further key activity. When `chord_valid && chord_ready` on an edge: `reported <= chord`, `chord_valid <= 0`, go to IDLE.
- Changes that occur during OFFER are not lost. After acceptance, IDLE compares the current `dbvec` with `reported` and offers again if they differ. Intermediate key sets that appear and disappear during OFFER are collapsed.
- Press-then-release back to `reported` while in IDLE produces no transaction, provided the press never reached the debounce threshold.
- Counters saturate only through the threshold compare and never wrap.

## Timing
- Reset values: `s1`, `s2`, `db`, `cnt`, `reported`, `chord` all 0; `chord_valid=0`; `any_key=0`; FSM in IDLE.
- Reset mid-operation: any pending offer is dropped with no handshake. Keys still held after reset are re-debounced from zero and offered as a fresh chord.
- Latency: counting the first edge that samples a new raw level into `s1` as edge 1:
  - `db` changes on edge DEBOUNCE_CYCLES+2.
  - `chord_valid` rises on edge DEBOUNCE_CYCLES+3, when the FSM is in IDLE.
- `any_key` follows `db` with 0 extra cycles; it is combinational from the `db` registers.
- Handshake completes on the edge where both `chord_valid` and `chord_ready` are high.
  - `chord_valid` is low for at least one cycle between consecutive offers.
  - Maximum throughput is one chord per 2 cycles.
- `chord_ready` high while `chord_valid` is low has no effect.
- Debounce counting continues during OFFER and during stalls.

## Test plan
- Reset, then DEBOUNCE_CYCLES=4: raise `t0` and hold it. `chord_valid` rises on edge 7 with `chord=8'h80` and `any_key=1`. With `chord_ready=1`, `chord_valid` falls on the next edge.
- Glitch rejection: pulse `t3` high for 3 cycles, then low. `chord_valid` never rises, `chord` stays 8'h00, and `any_key` stays 0.
- Backpressure: hold `chord_ready=0`, press `t7` (offer 8'h01), then also press `t6`. `chord` stays 8'h01 until ready. After acceptance and one idle cycle, a new offer `chord=8'h03` appears.
- Release reporting: accept chord 8'h81, then release both keys. A new offer `chord=8'h00` appears after debounce.
- Simultaneous keys: raise `t0`..`t7` on the same edge. A single offer `chord=8'hFF` appears on edge 7.
- Reset mid-offer: while `chord_valid=1` with 8'h10 held, assert `rst` for 1 cycle and keep the key held. Outputs read 0 on the edge after reset. 8'h10 is re-offered DEBOUNCE_CYCLES+3 edges after `rst` deasserts.

Source files
------------

// File: rtl/piano_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : piano_key_debounce
// Brief    : Synchronizes and debounces eight piano keys and offers each new
//            debounced chord downstream through a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module piano_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       t0,
    input  logic       t1,
    input  logic       t2,
    input  logic       t3,
    input  logic       t4,
    input  logic       t5,
    input  logic       t6,
    input  logic       t7,
    output logic [7:0] chord,
    output logic       chord_valid,
    input  logic       chord_ready,
    output logic       any_key
);

    localparam logic [CNT_W-1:0] c_THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // t0 lands in bit 7 so the vector matches the downstream chord layout
    logic [7:0] w_raw;
    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] w_dbvec;
    logic [7:0] r_reported;
    logic [7:0] r_chord;
    logic       r_chord_valid;
    state_t     r_state;

    assign w_raw = {t0, t1, t2, t3, t4, t5, t6, t7};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_key
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;

        // A level is accepted only after it has disagreed with r_db for
        // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_s2[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_THRESH) begin
                r_db  <= r_s2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_dbvec[i] = r_db;
    end

    assign any_key = |w_dbvec;

    // The offer is frozen until accepted; later key changes are picked up by
    // the IDLE compare against the last accepted chord.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_chord       <= 8'h00;
            r_chord_valid <= 1'b0;
            r_reported    <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dbvec != r_reported) begin
                        r_chord       <= w_dbvec;
                        r_chord_valid <= 1'b1;
                        r_state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (chord_ready) begin
                        r_reported    <= r_chord;
                        r_chord_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_chord_valid <= 1'b0;
                end
            endcase
        end
    end

    assign chord       = r_chord;
    assign chord_valid = r_chord_valid;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_piano_key_debounce
// Brief    : Directed self-checking bench for piano_key_debounce (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_piano_key_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t0 = 1'b0, t1 = 1'b0, t2 = 1'b0, t3 = 1'b0;
    logic       t4 = 1'b0, t5 = 1'b0, t6 = 1'b0, t7 = 1'b0;
    logic [7:0] chord;
    logic       chord_valid;
    logic       chord_ready = 1'b0;
    logic       any_key;

    int errors = 0;
    int checks = 0;

    piano_key_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .t0         (t0),
        .t1         (t1),
        .t2         (t2),
        .t3         (t3),
        .t4         (t4),
        .t5         (t5),
        .t6         (t6),
        .t7         (t7),
        .chord      (chord),
        .chord_valid(chord_valid),
        .chord_ready(chord_ready),
        .any_key    (any_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_keys(input logic [7:0] v);
        {t0, t1, t2, t3, t4, t5, t6, t7} = v;
    endtask

    initial begin
        ticks(2);
        check("reset_chord", chord, 8'h00);
        check("reset_valid", 8'(chord_valid), 8'h00);
        check("reset_any", 8'(any_key), 8'h00);
        rst = 1'b0;

        // Glitch: t3 high for 3 cycles never debounces
        set_keys(8'h10);
        ticks(3);
        set_keys(8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_valid", 8'(chord_valid), 8'h00);
            check("glitch_any", 8'(any_key), 8'h00);
        end
        check("glitch_chord", chord, 8'h00);

        // Single key t0: db on edge 6, offer on edge 7
        set_keys(8'h80);
        ticks(5);
        check("t0_any_e5", 8'(any_key), 8'h00);
        tick();
        check("t0_any_e6", 8'(any_key), 8'h01);
        check("t0_valid_e6", 8'(chord_valid), 8'h00);
        tick();
        check("t0_valid_e7", 8'(chord_valid), 8'h01);
        check("t0_chord_e7", chord, 8'h80);
        chord_ready = 1'b1;
        tick();
        check("t0_accept", 8'(chord_valid), 8'h00);

        // Add t7 -> 0x81, accept, then release both -> 0x00
        set_keys(8'h81);
        ticks(7);
        check("81_valid", 8'(chord_valid), 8'h01);
        check("81_chord", chord, 8'h81);
        tick();
        check("81_accept", 8'(chord_valid), 8'h00);
        set_keys(8'h00);
        ticks(6);
        check("rel_any_e6", 8'(any_key), 8'h00);
        check("rel_valid_e6", 8'(chord_valid), 8'h00);
        tick();
        check("rel_valid_e7", 8'(chord_valid), 8'h01);
        check("rel_chord", chord, 8'h00);
        tick();
        check("rel_accept", 8'(chord_valid), 8'h00);

        // Backpressure: 0x01 held while t6 joins, then 0x03 after one idle cycle
        chord_ready = 1'b0;
        set_keys(8'h01);
        ticks(7);
        check("bp_valid", 8'(chord_valid), 8'h01);
        check("bp_chord", chord, 8'h01);
        set_keys(8'h03);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_chord", chord, 8'h01);
            check("bp_hold_valid", 8'(chord_valid), 8'h01);
        end
        check("bp_any", 8'(any_key), 8'h01);
        chord_ready = 1'b1;
        tick();
        check("bp_accept", 8'(chord_valid), 8'h00);
        tick();
        check("bp_reoffer_valid", 8'(chord_valid), 8'h01);
        check("bp_reoffer_chord", chord, 8'h03);
        tick();
        check("bp_reoffer_accept", 8'(chord_valid), 8'h00);
        set_keys(8'h00);
        ticks(7);
        check("bp_rel_chord", chord, 8'h00);
        check("bp_rel_valid", 8'(chord_valid), 8'h01);
        tick();

        // All keys on the same edge -> a single 0xFF offer
        set_keys(8'hFF);
        ticks(6);
        check("all_valid_e6", 8'(chord_valid), 8'h00);
        tick();
        check("all_valid_e7", 8'(chord_valid), 8'h01);
        check("all_chord", chord, 8'hFF);
        tick();
        check("all_accept", 8'(chord_valid), 8'h00);
        tick();
        check("all_single", 8'(chord_valid), 8'h00);
        set_keys(8'h00);
        ticks(8);
        check("all_rel_valid", 8'(chord_valid), 8'h00);
        check("all_rel_any", 8'(any_key), 8'h00);

        // Reset mid-offer: drop 0x10 then re-offer it fresh
        chord_ready = 1'b0;
        set_keys(8'h10);
        ticks(7);
        check("mid_valid", 8'(chord_valid), 8'h01);
        check("mid_chord", chord, 8'h10);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_chord", chord, 8'h00);
        check("mid_rst_valid", 8'(chord_valid), 8'h00);
        check("mid_rst_any", 8'(any_key), 8'h00);
        ticks(6);
        check("mid_re_valid_e6", 8'(chord_valid), 8'h00);
        tick();
        check("mid_re_valid_e7", 8'(chord_valid), 8'h01);
        check("mid_re_chord", chord, 8'h10);
        chord_ready = 1'b1;
        tick();
        check("mid_re_accept", 8'(chord_valid), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
